// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: decodes UART command frames into register-file, ALU and TX FIFO transactions
module cmd_frame_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    WR_EN,
    output logic                    RD_EN,
    output logic [ADDR_WIDTH-1:0]   ADDRESS,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    CMD_ERR
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA_S, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_LSB, TX_MSB
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic                    two_q, two_d;
    logic                    clk_gate_en_q, clk_gate_en_d;
    logic                    wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
    logic                    tx_d_vld_q, tx_d_vld_d, cmd_err_q, cmd_err_d;

    // Next-state and registered-output logic; pulses default low, data outputs hold
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        wr_data_d     = wr_data_q;
        alu_fun_d     = alu_fun_q;
        tx_p_data_d   = tx_p_data_q;
        res_d         = res_q;
        two_d         = two_q;
        clk_gate_en_d = clk_gate_en_q;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        alu_en_d      = 1'b0;
        tx_d_vld_d    = 1'b0;
        cmd_err_d     = 1'b0;
        case (state_q)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == DATA_WIDTH'(8'hAA)) state_d = WR_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(8'hBB)) state_d = RD_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(8'hCC)) begin
                    state_d       = OP_A;
                    clk_gate_en_d = 1'b1;
                end else if (RX_P_DATA == DATA_WIDTH'(8'hDD)) begin
                    state_d       = ALU_FUN_S;
                    clk_gate_en_d = 1'b1;
                end else cmd_err_d = 1'b1;
            end
            WR_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d   = WR_DATA_S;
            end
            WR_DATA_S: if (RX_D_VLD) begin
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_d   = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: if (RF_RD_DATA_VLD) begin
                res_d   = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                two_d   = 1'b0;
                state_d = TX_LSB;
            end
            OP_A: if (RX_D_VLD) begin
                address_d = '0;
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = OP_B;
            end
            OP_B: if (RX_D_VLD) begin
                address_d = ADDR_WIDTH'(1);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = ALU_FUN_S;
            end
            ALU_FUN_S: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[3:0];
                alu_en_d  = 1'b1;
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: if (ALU_OUT_VLD) begin
                res_d         = ALU_OUT;
                two_d         = 1'b1;
                clk_gate_en_d = 1'b0;
                state_d       = TX_LSB;
            end
            TX_LSB: if (!FIFO_FULL) begin
                tx_p_data_d = res_q[DATA_WIDTH-1:0];
                tx_d_vld_d  = 1'b1;
                state_d     = two_q ? TX_MSB : IDLE;
            end
            TX_MSB: if (!FIFO_FULL) begin
                tx_p_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                tx_d_vld_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a partial frame is dropped
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            address_q     <= '0;
            wr_data_q     <= '0;
            alu_fun_q     <= '0;
            tx_p_data_q   <= '0;
            res_q         <= '0;
            two_q         <= 1'b0;
            clk_gate_en_q <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            alu_en_q      <= 1'b0;
            tx_d_vld_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            wr_data_q     <= wr_data_d;
            alu_fun_q     <= alu_fun_d;
            tx_p_data_q   <= tx_p_data_d;
            res_q         <= res_d;
            two_q         <= two_d;
            clk_gate_en_q <= clk_gate_en_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            alu_en_q      <= alu_en_d;
            tx_d_vld_q    <= tx_d_vld_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign RD_EN       = rd_en_q;
    assign ADDRESS     = address_q;
    assign WR_DATA     = wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign TX_P_DATA   = tx_p_data_q;
    assign TX_D_VLD    = tx_d_vld_q;
    assign CMD_ERR     = cmd_err_q;
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: scoreboard bench for the command frame decoder
module tb_cmd_frame_decoder;
    logic        CLK = 0, RST = 0;
    logic [7:0]  RX_P_DATA = 0, RF_RD_DATA = 0;
    logic        RX_D_VLD = 0, RF_RD_DATA_VLD = 0, ALU_OUT_VLD = 0, FIFO_FULL = 0;
    logic [15:0] ALU_OUT = 0;
    logic        WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
    logic [3:0]  ADDRESS, ALU_FUN;
    logic [7:0]  WR_DATA, TX_P_DATA;

    int checks = 0, errs = 0;
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  alu_q[$];
    logic [7:0]  tx_q[$];
    int          err_exp = 0;
    logic [11:0] wr_e;
    logic [3:0]  a_e;
    logic [7:0]  t_e;

    cmd_frame_decoder dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .ADDRESS(ADDRESS), .WR_DATA(WR_DATA),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Pops the scoreboard whenever the DUT emits a pulse
    always @(negedge CLK) begin
        if (WR_EN && RD_EN) begin
            checks++; errs++;
            $display("FAIL wr_rd_overlap: WR_EN and RD_EN both high");
        end
        if (WR_EN) begin
            checks++;
            if (wr_q.size() == 0) begin
                errs++; $display("FAIL wr_unexpected: addr=%0h data=%0h, expected no write", ADDRESS, WR_DATA);
            end else begin
                wr_e = wr_q.pop_front();
                if ({ADDRESS, WR_DATA} !== wr_e) begin
                    errs++; $display("FAIL wr_event: got %h, expected %h", {ADDRESS, WR_DATA}, wr_e);
                end
            end
        end
        if (RD_EN) begin
            checks++;
            if (rd_q.size() == 0) begin
                errs++; $display("FAIL rd_unexpected: addr=%0h, expected no read", ADDRESS);
            end else begin
                a_e = rd_q.pop_front();
                if (ADDRESS !== a_e) begin
                    errs++; $display("FAIL rd_addr: got %0h, expected %0h", ADDRESS, a_e);
                end
            end
        end
        if (ALU_EN) begin
            checks++;
            if (alu_q.size() == 0) begin
                errs++; $display("FAIL alu_unexpected: fun=%0h, expected no ALU_EN", ALU_FUN);
            end else begin
                a_e = alu_q.pop_front();
                if (ALU_FUN !== a_e || CLK_GATE_EN !== 1'b1) begin
                    errs++; $display("FAIL alu_event: fun=%0h gate=%b, expected fun=%0h gate=1", ALU_FUN, CLK_GATE_EN, a_e);
                end
            end
        end
        if (TX_D_VLD) begin
            checks++;
            if (tx_q.size() == 0) begin
                errs++; $display("FAIL tx_unexpected: data=%0h, expected no push", TX_P_DATA);
            end else begin
                t_e = tx_q.pop_front();
                if (TX_P_DATA !== t_e) begin
                    errs++; $display("FAIL tx_data: got %0h, expected %0h", TX_P_DATA, t_e);
                end
            end
        end
        if (CMD_ERR) begin
            checks++;
            if (err_exp == 0) begin
                errs++; $display("FAIL cmd_err_unexpected: CMD_ERR=1, expected 0");
            end else err_exp--;
        end
    end

    function automatic int pending();
        return wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_exp;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b; RX_D_VLD = 1;
        @(posedge CLK); #1;
        RX_D_VLD = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && pending() != 0; i++) @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (pending() != 0) begin
            errs++;
            $display("FAIL %s_drain: %0d events outstanding, expected 0", name, pending());
            wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); err_exp = 0;
        end
    endtask

    task automatic test_reset();
        RST = 0;
        #23;
        checks++;
        if ({WR_EN, RD_EN, ALU_EN, TX_D_VLD, CMD_ERR, CLK_GATE_EN, ADDRESS, WR_DATA, ALU_FUN, TX_P_DATA} !== '0) begin
            errs++; $display("FAIL reset_outputs: some output nonzero, expected all 0");
        end
        RST = 1;
    endtask

    task automatic test_write();
        wr_q.push_back({4'h5, 8'h77});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h77);
        drain("write");
        checks++;
        if (ADDRESS !== 4'h5 || WR_DATA !== 8'h77) begin
            errs++; $display("FAIL write_hold: addr=%0h data=%0h, expected 5/77", ADDRESS, WR_DATA);
        end
    endtask

    task automatic test_read();
        rd_q.push_back(4'h2);
        send_byte(8'hBB); send_byte(8'h02);
        send_byte(8'h55);
        tx_q.push_back(8'h3C);
        @(posedge CLK); #1;
        RF_RD_DATA = 8'h3C; RF_RD_DATA_VLD = 1;
        @(posedge CLK); #1;
        RF_RD_DATA_VLD = 0;
        drain("read");
    endtask

    task automatic test_alu_ops();
        send_byte(8'hCC);
        checks++;
        if (CLK_GATE_EN !== 1'b1) begin
            errs++; $display("FAIL gate_on: CLK_GATE_EN=%b, expected 1", CLK_GATE_EN);
        end
        wr_q.push_back({4'h0, 8'h05}); wr_q.push_back({4'h1, 8'h03}); alu_q.push_back(4'h1);
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h01);
        repeat (2) @(posedge CLK); #1;
        checks++;
        if (CLK_GATE_EN !== 1'b1) begin
            errs++; $display("FAIL gate_hold: CLK_GATE_EN=%b, expected 1", CLK_GATE_EN);
        end
        tx_q.push_back(8'h02); tx_q.push_back(8'h00);
        ALU_OUT = 16'h0002; ALU_OUT_VLD = 1;
        @(posedge CLK); #1;
        ALU_OUT_VLD = 0;
        checks++;
        if (CLK_GATE_EN !== 1'b0) begin
            errs++; $display("FAIL gate_off: CLK_GATE_EN=%b, expected 0", CLK_GATE_EN);
        end
        drain("alu_ops");
    endtask

    task automatic test_back_to_back_full();
        logic [7:0] held;
        FIFO_FULL = 1;
        alu_q.push_back(4'h1);
        send_byte(8'hDD); send_byte(8'h01);
        @(posedge CLK); #1;
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1;
        @(posedge CLK); #1;
        ALU_OUT_VLD = 0;
        held = TX_P_DATA;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (TX_D_VLD !== 1'b0 || TX_P_DATA !== held) begin
                errs++; $display("FAIL full_hold: vld=%b data=%0h, expected 0/%0h", TX_D_VLD, TX_P_DATA, held);
            end
        end
        tx_q.push_back(8'h34); tx_q.push_back(8'h12);
        FIFO_FULL = 0;
        drain("backpressure");
    endtask

    task automatic test_unknown();
        err_exp = 1;
        send_byte(8'h55);
        drain("unknown");
        wr_q.push_back({4'h3, 8'h11});
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        drain("after_unknown");
    endtask

    task automatic test_reset_mid();
        wr_q.push_back({4'h0, 8'h05});
        send_byte(8'hCC); send_byte(8'h05);
        @(posedge CLK); #3;
        RST = 0;
        #1;
        checks++;
        if ({WR_EN, RD_EN, ALU_EN, TX_D_VLD, CMD_ERR, CLK_GATE_EN, ADDRESS, WR_DATA, ALU_FUN, TX_P_DATA} !== '0) begin
            errs++; $display("FAIL reset_mid: gate=%b wr_data=%0h tx=%0h, expected all 0", CLK_GATE_EN, WR_DATA, TX_P_DATA);
        end
        #10 RST = 1;
        rd_q.push_back(4'h1);
        send_byte(8'hBB); send_byte(8'h01);
        tx_q.push_back(8'hA5);
        @(posedge CLK); #1;
        RF_RD_DATA = 8'hA5; RF_RD_DATA_VLD = 1;
        @(posedge CLK); #1;
        RF_RD_DATA_VLD = 0;
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_back_to_back_full();
        test_unknown();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule

// File: doc/cmd_frame_decoder.md
CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of UART payload and register file data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register file address width.
REQ-003 SHALL have the port CLK  in  1  as its single clock; all logic is rising-edge.
REQ-004 SHALL have the port RST  in  1  as its reset, asynchronous and active-low.
REQ-005 SHALL have the port RX_P_DATA  in  DATA_WIDTH  as the received byte from the UART RX data synchronizer.
REQ-006 SHALL have the port RX_D_VLD  in  1  as a one-cycle pulse marking RX_P_DATA valid.
REQ-007 SHALL have the port RF_RD_DATA  in  DATA_WIDTH  as register file read data.
REQ-008 SHALL have the port RF_RD_DATA_VLD  in  1  as register file read data valid.
REQ-009 SHALL have the port ALU_OUT  in  2*DATA_WIDTH  as the ALU result.
REQ-010 SHALL have the port ALU_OUT_VLD  in  1  as the ALU result valid.
REQ-011 SHALL have the port FIFO_FULL  in  1  as the TX async FIFO full flag.
REQ-012 SHALL have the ports WR_EN / RD_EN  out  1 / 1  as register file write and read strobes.
REQ-013 SHALL have the ports ADDRESS / WR_DATA  out  ADDR_WIDTH / DATA_WIDTH  as register file address and write data.
REQ-014 SHALL have the ports ALU_EN / ALU_FUN / CLK_GATE_EN  out  1 / 4 / 1  as ALU start pulse, ALU function, and ALU clock-gate enable.
REQ-015 SHALL have the ports TX_P_DATA / TX_D_VLD  out  DATA_WIDTH / 1  as the FIFO write byte and write strobe.
REQ-016 SHALL have the port CMD_ERR  out  1  as a one-cycle pulse flagging an unknown command byte.

Function
REQ-017 SHALL register all outputs; WR_EN, RD_EN, ALU_EN, TX_D_VLD and CMD_ERR are single-cycle pulses.
REQ-018 SHALL support four commands keyed by the first byte: 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU no operands (fun).
REQ-019 SHALL implement the FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB.
REQ-020 SHALL in IDLE, on an RX_D_VLD byte, go to WR_ADDR on 0xAA, RD_ADDR on 0xBB, OP_A on 0xCC, ALU_FUN on 0xDD; any other byte pulses CMD_ERR next cycle and stays in IDLE.
REQ-021 SHALL in WR_ADDR latch RX_P_DATA[ADDR_WIDTH-1:0] into ADDRESS on the next byte; in WR_DATA, on the next byte, drive WR_DATA=byte with WR_EN high for one cycle the cycle after RX_D_VLD, then return to IDLE.
REQ-022 SHALL in RD_ADDR, on the next byte, drive ADDRESS and pulse RD_EN the cycle after, then go to RD_WAIT.
REQ-023 SHALL in RD_WAIT latch RF_RD_DATA on RF_RD_DATA_VLD, then go to TX_LSB and push that single byte, then return to IDLE.
REQ-024 SHALL in OP_A write the byte to address 0, and in OP_B write the byte to address 1, each with WR_EN timing as in REQ-021.
REQ-025 SHALL in ALU_FUN, on the next byte, hold ALU_FUN=byte[3:0] and pulse ALU_EN the cycle after, then go to ALU_WAIT.
REQ-026 SHALL hold CLK_GATE_EN high from entry to OP_A (0xCC) or ALU_FUN (0xDD) until ALU_OUT_VLD is seen in ALU_WAIT; it is low otherwise.
REQ-027 SHALL in ALU_WAIT latch ALU_OUT on ALU_OUT_VLD, then push the LSB byte (TX_LSB) then the MSB byte (TX_MSB), then return to IDLE.
REQ-028 SHALL in TX_LSB/TX_MSB assert TX_D_VLD only in a cycle where FIFO_FULL is low; while FIFO_FULL is high, no push occurs, the state holds and TX_P_DATA is stable.
REQ-029 SHALL ignore RX_D_VLD bytes arriving in RD_WAIT, ALU_WAIT, TX_LSB and TX_MSB, with no state change and no output effect.
REQ-030 SHALL never issue WR_EN and RD_EN in the same cycle.

Reset
REQ-031 SHALL, on RST low at any time including mid-command, immediately force the state to IDLE and all outputs to 0 (ADDRESS, WR_DATA, ALU_FUN, TX_P_DATA = 0; CLK_GATE_EN = 0); the partial command is discarded.
REQ-032 SHALL treat the first byte after reset release as a command byte.

Verification
REQ-033 SHALL be covered by a bench test of the write command: bytes 0xAA,0x05,0x77 -> one WR_EN pulse with ADDRESS=5 and WR_DATA=0x77, and no TX_D_VLD.
REQ-034 SHALL be covered by a bench test of the read command: bytes 0xBB,0x02, then RF returns 0x3C -> RD_EN pulse with ADDRESS=2, then one TX_D_VLD with TX_P_DATA=0x3C.
REQ-035 SHALL be covered by a bench test of the ALU-with-operands command: bytes 0xCC,0x05,0x03,0x01 -> writes reg0=0x05 and reg1=0x03, ALU_EN with ALU_FUN=1 and CLK_GATE_EN high; ALU returns 0x0002 -> pushes 0x02 then 0x00, and CLK_GATE_EN drops.
REQ-036 SHALL be covered by a bench test of FIFO back-pressure: 0xDD,0x01 with ALU_OUT=0x1234 and FIFO_FULL high for 5 cycles -> no push while full, then 0x34 then 0x12 pushed.
REQ-037 SHALL be covered by a bench test of an unknown byte: byte 0x55 -> CMD_ERR pulse, then 0xAA,0x03,0x11 -> normal write.
REQ-038 SHALL be covered by a bench test of reset mid-command: RST pulsed after 0xCC,0x05 -> outputs 0 and CLK_GATE_EN low, then 0xBB,0x01 decodes as a read.
